// File: rtl/cpu_pkg.sv
// Shared CPU constants and helpers for the register-read path.
package cpu_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int TAG_W     = 4;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  // A commit landing on the read edge supplies the value the register file cannot yet return.
  function automatic logic byp_hit(input logic                 wb_valid,
                                   input logic [REG_IDX_W-1:0] wb_rd,
                                   input logic [REG_IDX_W-1:0] rs);
    return wb_valid && (wb_rd == rs) && (rs != REG_ZERO);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant over NUM_REQ requesters, searching from
// ptr upward; ptr moves just past the winner on each granted cycle.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               active_in,
  input  logic [NUM_REQ-1:0] req_in,
  output logic [NUM_REQ-1:0] grant_out,
  output logic [IDX_W-1:0]   winner_out,
  output logic               any_out
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             hit;
  int               idx;

  // Wrap-around priority search plus pointer advance
  always_comb begin
    grant_out  = '0;
    winner_out = '0;
    any_out    = 1'b0;
    hit        = 1'b0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx            = (int'(ptr_q) + k) % NUM_REQ;
      hit            = active_in && !any_out && req_in[idx];
      grant_out[idx] = hit;
      winner_out     = hit ? IDX_W'(idx) : winner_out;
      any_out        = any_out | hit;
    end
    if (any_out) begin
      ptr_d = (winner_out == IDX_W'(NUM_REQ - 1)) ? '0 : winner_out + IDX_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/reg_read_arbiter.sv
// Shares the register file read port among NUM_REQ dispatch requesters and
// returns bypass-corrected operands one cycle after grant.
module reg_read_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = cpu_pkg::XLEN,
  parameter int TAG_W   = cpu_pkg::TAG_W
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*5-1:0] req_rs1,
  input  logic [NUM_REQ*5-1:0] req_rs2,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rf_rd_en,
  output logic [4:0]           rf_rs1,
  output logic [4:0]           rf_rs2,
  input  logic [XLEN-1:0]      rf_rdata1,
  input  logic [XLEN-1:0]      rf_rdata2,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic [XLEN-1:0]      rsp_rdata1,
  output logic [XLEN-1:0]      rsp_rdata2
);

  import cpu_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                 active;
  logic [IDX_W-1:0]     winner;
  logic                 any_grant;
  logic [REG_IDX_W-1:0] win_rs1, win_rs2;
  logic [TAG_W-1:0]     win_tag;

  logic                 s1_valid_q, s1_valid_d;
  logic [IDX_W-1:0]     s1_id_q, s1_id_d;
  logic [TAG_W-1:0]     s1_tag_q, s1_tag_d;
  logic [REG_IDX_W-1:0] s1_rs1_q, s1_rs1_d, s1_rs2_q, s1_rs2_d;
  logic                 s1_byp1_q, s1_byp1_d, s1_byp2_q, s1_byp2_d;
  logic [XLEN-1:0]      s1_wbd_q, s1_wbd_d;

  function automatic logic [XLEN-1:0] operand(input logic [REG_IDX_W-1:0] rs,
                                              input logic                 byp,
                                              input logic [XLEN-1:0]      wbd,
                                              input logic [XLEN-1:0]      rfd);
    if (rs == REG_ZERO) begin
      return {XLEN{1'b0}};
    end else if (byp) begin
      return wbd;
    end else begin
      return rfd;
    end
  endfunction

  // Reset is folded in so the grant outputs read zero while rst_n_in is low.
  assign active = rst_n_in && rdy_in && !flush_in;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .active_in  (active),
    .req_in     (req_valid),
    .grant_out  (req_ready),
    .winner_out (winner),
    .any_out    (any_grant)
  );

  // Winner's fields and the register-file read strobe
  always_comb begin
    win_rs1 = req_rs1[int'(winner)*REG_IDX_W +: REG_IDX_W];
    win_rs2 = req_rs2[int'(winner)*REG_IDX_W +: REG_IDX_W];
    win_tag = req_tag[int'(winner)*TAG_W +: TAG_W];
    if (any_grant) begin
      rf_rd_en = 1'b1;
      rf_rs1   = win_rs1;
      rf_rs2   = win_rs2;
    end else begin
      rf_rd_en = 1'b0;
      rf_rs1   = 5'd0;
      rf_rs2   = 5'd0;
    end
  end

  // S1 next state: capture on grant, clear on an enabled idle/flush edge, hold when stalled
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s1_tag_d   = s1_tag_q;
    s1_rs1_d   = s1_rs1_q;
    s1_rs2_d   = s1_rs2_q;
    s1_byp1_d  = s1_byp1_q;
    s1_byp2_d  = s1_byp2_q;
    s1_wbd_d   = s1_wbd_q;
    if (rdy_in) begin
      if (any_grant) begin
        s1_valid_d = 1'b1;
        s1_id_d    = winner;
        s1_tag_d   = win_tag;
        s1_rs1_d   = win_rs1;
        s1_rs2_d   = win_rs2;
        s1_byp1_d  = byp_hit(wb_valid, wb_rd, win_rs1);
        s1_byp2_d  = byp_hit(wb_valid, wb_rd, win_rs2);
        s1_wbd_d   = wb_data;
      end else begin
        s1_valid_d = 1'b0;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // S1 pipeline register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_tag_q   <= '0;
      s1_rs1_q   <= '0;
      s1_rs2_q   <= '0;
      s1_byp1_q  <= 1'b0;
      s1_byp2_q  <= 1'b0;
      s1_wbd_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_tag_q   <= s1_tag_d;
      s1_rs1_q   <= s1_rs1_d;
      s1_rs2_q   <= s1_rs2_d;
      s1_byp1_q  <= s1_byp1_d;
      s1_byp2_q  <= s1_byp2_d;
      s1_wbd_q   <= s1_wbd_d;
    end
  end

  // Response mux; a flush or stall in the response cycle suppresses every rsp_* output
  always_comb begin
    rsp_valid  = '0;
    rsp_tag    = '0;
    rsp_rdata1 = '0;
    rsp_rdata2 = '0;
    if (s1_valid_q && rdy_in && !flush_in) begin
      rsp_valid[s1_id_q] = 1'b1;
      rsp_tag            = s1_tag_q;
      rsp_rdata1         = operand(s1_rs1_q, s1_byp1_q, s1_wbd_q, rf_rdata1);
      rsp_rdata2         = operand(s1_rs2_q, s1_byp2_q, s1_wbd_q, rf_rdata2);
    end else begin
      rsp_valid = '0;
    end
  end

endmodule

// File: doc/reg_read_arbiter.md
# reg_read_arbiter

Shares the register file's single two-operand read port among up to four dispatch requesters (reservation station, load/store buffer, …) using round-robin arbitration. Sits between the dispatch units and the register file, drives the file's read enable and addresses, and returns the read operands one cycle after grant. Data is corrected for a ROB commit that lands on the same edge as the read, and x0 reads are forced to zero.

## Interface
- NUM_REQ, 2: number of requesters, legal 2..4.
- XLEN, 32: data width.
- TAG_W, 4: requester tag width, echoed in the response.
- clk_in  in  1  clock.
- rst_n_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global enable; low freezes the block.
- flush_in  in  1  misprediction flush.
- req_valid  in  NUM_REQ  per-requester read request.
- req_rs1, req_rs2  in  NUM_REQ*5 each  source register indices, requester i in bits [5i+4:5i].
- req_tag  in  NUM_REQ*TAG_W  requester tag.
- req_ready  out  NUM_REQ  one-hot grant; the request is consumed in this cycle.
- rf_rd_en  out  1  read strobe to the register file.
- rf_rs1, rf_rs2  out  5 each  read addresses to the register file.
- rf_rdata1, rf_rdata2  in  XLEN each  register-file read data, valid the cycle after the strobe.
- wb_valid, wb_rd, wb_data  in  1/5/XLEN  ROB commit write, the same values driven into the register file.
- rsp_valid  out  NUM_REQ  one-hot response.
- rsp_tag  out  TAG_W  tag of the response.
- rsp_rdata1, rsp_rdata2  out  XLEN each  operand values.

## Operation
- Grant (combinational):
  - Active only when rdy_in=1 and flush_in=0.
  - Winner is the first requester with req_valid set, searching from ptr upward with wrap-around.
  - req_ready[winner]=1, rf_rd_en=1, rf_rs1/rf_rs2 = the winner's addresses.
  - With no grant, rf_rd_en=0 and rf_rs1/rf_rs2=0.
- On each granted edge:
  - ptr <= (winner+1) mod NUM_REQ.
  - The S1 stage captures valid=1, winner id, tag, rs1, rs2.
  - Per operand, S1 also captures byp = wb_valid && wb_rd==rs && rs!=0, plus wb_data.
- Edge with rdy_in=1 and no grant: S1.valid <= 0.
- Edge with rdy_in=1 and flush_in=1: S1.valid <= 0. ptr is unchanged.
- rdy_in=0: ptr and S1 hold. The register file also holds its outputs.
- Response (combinational from S1):
  - rsp_valid = onehot(S1.id) when S1.valid && rdy_in && !flush_in, otherwise 0.
  - Operand value = 0 if rs==0, else wb_data if byp, else rf_rdata.
  - rsp_tag = S1.tag.
  - When rsp_valid=0, all rsp_* outputs are 0.
- No backpressure on responses; requesters must accept any rsp_valid.
- Register-file reads return pre-write data on a simultaneous write edge. The byp capture supplies the new value in that case.

## Timing
- Reset (async assert): ptr=0, S1.valid=0, all outputs 0, regardless of inputs.
- Reset deassert is synchronised externally. The first grant can occur in the first cycle after deassert.
- Latency: grant in cycle N, response in cycle N+1, one response per cycle.
- Throughput: 1 grant/cycle. Back-to-back grants overlap grant and response.
- Flush in the grant cycle: no grant.
- Flush in the response cycle: that response is dropped and the requester must reissue.
- A commit in cycle N+1 is not reflected in the N+1 response. The ROB/RS wakeup path covers that case.
- Reset mid-stream: a pending S1 response is discarded and rsp_valid drops asynchronously.

## Structure
- Shared package (cpu_pkg): XLEN, REG_IDX_W=5, REG_ZERO=5'd0, TAG_W default.
- Sub-module rr_arbiter: NUM_REQ request vector in, one-hot grant out, owns ptr; advances on an enable input.
- The top level holds the S1 register, bypass compare and output mux.

## Test plan
- Single request: x3=0x11, x5=0x22; req_valid=01, rs1=3, rs2=5, tag=7 -> cycle N req_ready=01, rf_rd_en=1, rf_rs1=3; cycle N+1 rsp_valid=01, rsp_rdata1=0x11, rsp_rdata2=0x22, rsp_tag=7.
- Fairness: both requesters held valid for 6 cycles after reset -> grants 0,1,0,1,0,1; responses follow one cycle later with matching tags.
- Bypass: grant reading rs1=3 with wb_valid=1, wb_rd=3, wb_data=0xDEAD in the same cycle -> rsp_rdata1=0xDEAD; rs2=5 still returns 0x22.
- x0: rs1=0 with wb_valid=1, wb_rd=0, wb_data=0xFF -> rsp_rdata1=0.
- Flush:
  - flush_in=1 in the grant cycle -> req_ready=0, no response.
  - flush_in=1 in the response cycle -> rsp_valid=0, and the next grant still follows the unchanged ptr.
- Stall/reset:
  - rdy_in=0 for 3 cycles after a grant -> rsp_valid=0 throughout; the response appears the cycle rdy_in returns.
  - rst_n_in=0 with S1 valid -> all outputs 0 immediately; after release the first grant goes to requester 0.
